// File: rtl/lmem_sched_pkg.sv
// Shared constants and FSM encoding for the L-memory layer sequencer.
package lmem_sched_pkg;

    localparam int DFLT_ADDRESSWIDTH = 5;
    localparam int DFLT_NADDR        = 20;
    localparam int DFLT_PIPE_LAT     = 4;
    localparam int DFLT_ITRWIDTH     = 5;
    localparam int DFLT_LAYER_PERIOD = DFLT_NADDR + DFLT_PIPE_LAT;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        FIN
    } state_e;

endpackage

// File: rtl/lmem_sched_delay.sv
// Fixed-depth 1-bit shift register; turns the read-enable stream into the matching write-enable stream.
module lmem_sched_delay #(
    parameter int PIPE_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [PIPE_LAT-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < PIPE_LAT; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[PIPE_LAT-1];

endmodule

// File: rtl/lmem_layer_sched.sv
// L-memory layer sequencer: per-layer read sweep, delayed write enables, layer/iteration tracking.
// Optional syndrome-based early termination is enabled with LMEM_SCHED_EARLY_TERM_EN.
module lmem_layer_sched
    import lmem_sched_pkg::*;
#(
    parameter int ADDRESSWIDTH = DFLT_ADDRESSWIDTH,
    parameter int NADDR        = DFLT_NADDR,
    parameter int PIPE_LAT     = DFLT_PIPE_LAT,
    parameter int ITRWIDTH     = DFLT_ITRWIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [ITRWIDTH-1:0]     max_itr_i,
`ifdef LMEM_SCHED_EARLY_TERM_EN
    input  logic                    syndrome_ok_i,
    output logic                    early_term_o,
`endif
    output logic                    rd_en_o,
    output logic [ADDRESSWIDTH-1:0] rd_address_o,
    output logic                    wr_en_o,
    output logic                    layer_o,
    output logic                    firstiter_o,
    output logic [ITRWIDTH-1:0]     itr_o,
    output logic                    busy_o,
    output logic                    done_o
);

    state_e                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [ADDRESSWIDTH-1:0] wcnt_q, wcnt_d;
    logic                    layer_q, layer_d;
    logic                    first_q, first_d;
    logic [ITRWIDTH-1:0]     itr_q, itr_d;
    logic [ITRWIDTH-1:0]     max_q, max_d;
    logic [ITRWIDTH:0]       itr_inc;
    logic                    rd_en, wr_en, last_wr;
`ifdef LMEM_SCHED_EARLY_TERM_EN
    logic                    eterm_q, eterm_d;
`endif

    assign rd_en   = (state_q == READ);
    assign last_wr = wr_en && (wcnt_q == ADDRESSWIDTH'(NADDR - 1));
    // one extra bit so itr+1 cannot wrap before the compare
    assign itr_inc = {1'b0, itr_q} + (ITRWIDTH + 1)'(1);

    lmem_sched_delay #(.PIPE_LAT(PIPE_LAT)) u_delay (
        .clk (clk),
        .rst (rst),
        .d_i (rd_en),
        .q_o (wr_en)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        layer_d = layer_q;
        first_d = first_q;
        itr_d   = itr_q;
        max_d   = max_q;
`ifdef LMEM_SCHED_EARLY_TERM_EN
        eterm_d = 1'b0;
`endif
        if (wr_en) begin
            wcnt_d = last_wr ? '0 : wcnt_q + ADDRESSWIDTH'(1);
        end
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    layer_d = 1'b0;
                    itr_d   = '0;
                    addr_d  = '0;
                    if (max_itr_i == '0) begin
                        state_d = FIN;
                        first_d = 1'b0;
                    end else begin
                        state_d = READ;
                        max_d   = max_itr_i;
                        first_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (addr_q == ADDRESSWIDTH'(NADDR - 1)) begin
                    addr_d  = '0;
                    state_d = WAIT;
                end else begin
                    addr_d = addr_q + ADDRESSWIDTH'(1);
                end
            end
            WAIT: begin
                // the next layer depends on this layer's writes, so hold until the last one
                if (last_wr) begin
                    if (!layer_q) begin
                        layer_d = 1'b1;
                        state_d = READ;
`ifdef LMEM_SCHED_EARLY_TERM_EN
                    end else if (syndrome_ok_i) begin
                        state_d = FIN;
                        eterm_d = 1'b1;
`endif
                    end else if (itr_inc < {1'b0, max_q}) begin
                        layer_d = 1'b0;
                        itr_d   = itr_inc[ITRWIDTH-1:0];
                        first_d = 1'b0;
                        state_d = READ;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                layer_d = 1'b0;
                first_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            layer_q <= 1'b0;
            first_q <= 1'b0;
            itr_q   <= '0;
            max_q   <= '0;
`ifdef LMEM_SCHED_EARLY_TERM_EN
            eterm_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            layer_q <= layer_d;
            first_q <= first_d;
            itr_q   <= itr_d;
            max_q   <= max_d;
`ifdef LMEM_SCHED_EARLY_TERM_EN
            eterm_q <= eterm_d;
`endif
        end
    end

    assign rd_en_o      = rd_en;
    assign rd_address_o = addr_q;
    assign wr_en_o      = wr_en;
    assign layer_o      = layer_q;
    assign firstiter_o  = first_q;
    assign itr_o        = itr_q;
    assign busy_o       = (state_q == READ) || (state_q == WAIT);
    assign done_o       = (state_q == FIN);
`ifdef LMEM_SCHED_EARLY_TERM_EN
    assign early_term_o = eterm_q;
`endif

endmodule

// File: tb/tb_lmem_layer_sched.sv
// Bench for lmem_layer_sched: spot-check vector table, cycle-exact reference model, reset/early-exit sequences.
module tb_lmem_layer_sched;
    import lmem_sched_pkg::*;

    localparam int NADDR = DFLT_NADDR;

    typedef struct {int rd; int addr; int wr; int layer; int first; int itr; int busy; int done; int et;} obs_t;
    typedef struct {int rd; int addr; int wr; int layer; int first; int itr; int busy; int done; int chk_itr;} exp_t;
    typedef struct {int lat; int m; int t; int rd; int addr; int wr; int layer; int first; int itr; int busy; int done;} vec_t;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [4:0] max_itr;
    logic       rd0, wr0, lay0, fi0, busy0, done0;
    logic       rd1, wr1, lay1, fi1, busy1, done1;
    logic [4:0] addr0, itr0, addr1, itr1;
`ifdef LMEM_SCHED_EARLY_TERM_EN
    logic       syn_ok, et0, et1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lmem_layer_sched #(.PIPE_LAT(4)) dut0 (
        .clk(clk), .rst(rst), .start_i(start), .max_itr_i(max_itr),
`ifdef LMEM_SCHED_EARLY_TERM_EN
        .syndrome_ok_i(syn_ok), .early_term_o(et0),
`endif
        .rd_en_o(rd0), .rd_address_o(addr0), .wr_en_o(wr0), .layer_o(lay0),
        .firstiter_o(fi0), .itr_o(itr0), .busy_o(busy0), .done_o(done0)
    );

    lmem_layer_sched #(.PIPE_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start), .max_itr_i(max_itr),
`ifdef LMEM_SCHED_EARLY_TERM_EN
        .syndrome_ok_i(syn_ok), .early_term_o(et1),
`endif
        .rd_en_o(rd1), .rd_address_o(addr1), .wr_en_o(wr1), .layer_o(lay1),
        .firstiter_o(fi1), .itr_o(itr1), .busy_o(busy1), .done_o(done1)
    );

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    function automatic obs_t sample(input int which);
        obs_t o;
        o.et = 0;
        if (which == 0) begin
            o.rd = int'(rd0); o.addr = int'(addr0); o.wr = int'(wr0); o.layer = int'(lay0);
            o.first = int'(fi0); o.itr = int'(itr0); o.busy = int'(busy0); o.done = int'(done0);
`ifdef LMEM_SCHED_EARLY_TERM_EN
            o.et = int'(et0);
`endif
        end else begin
            o.rd = int'(rd1); o.addr = int'(addr1); o.wr = int'(wr1); o.layer = int'(lay1);
            o.first = int'(fi1); o.itr = int'(itr1); o.busy = int'(busy1); o.done = int'(done1);
`ifdef LMEM_SCHED_EARLY_TERM_EN
            o.et = int'(et1);
`endif
        end
        return o;
    endfunction

    // Expected outputs t cycles after start was sampled: 2*m layers, each period NADDR+plat long.
    function automatic exp_t model(input int t, input int m, input int plat);
        exp_t e = '{default: 0};
        int per = NADDR + plat;
        int k, o;
        if (t >= 1) begin
            k = (t - 1) / per;
            o = (t - 1) % per;
            if (k < 2 * m) begin
                e.rd      = (o < NADDR) ? 1 : 0;
                e.addr    = (o < NADDR) ? o : 0;
                e.wr      = (o >= plat && o < plat + NADDR) ? 1 : 0;
                e.layer   = k % 2;
                e.first   = (k < 2) ? 1 : 0;
                e.itr     = k / 2;
                e.busy    = 1;
                e.chk_itr = 1;
            end else if (t == 2 * m * per + 1) begin
                e.done = 1;
                if (m > 0) begin
                    e.itr     = m - 1;
                    e.chk_itr = 1;
                end
            end
        end
        return e;
    endfunction

    task automatic check_cycle(input int t, input int m, input int plat, input obs_t g);
        exp_t e = model(t, m, plat);
        chk($sformatf("rd_en lat%0d m%0d", plat, m), t, g.rd, e.rd);
        chk($sformatf("rd_address lat%0d m%0d", plat, m), t, g.addr, e.addr);
        chk($sformatf("wr_en lat%0d m%0d", plat, m), t, g.wr, e.wr);
        chk($sformatf("busy lat%0d m%0d", plat, m), t, g.busy, e.busy);
        chk($sformatf("done lat%0d m%0d", plat, m), t, g.done, e.done);
        if (e.busy != 0) begin
            chk($sformatf("layer lat%0d m%0d", plat, m), t, g.layer, e.layer);
            chk($sformatf("firstiter lat%0d m%0d", plat, m), t, g.first, e.first);
        end
        if (e.chk_itr != 0) chk($sformatf("itr lat%0d m%0d", plat, m), t, g.itr, e.itr);
`ifdef LMEM_SCHED_EARLY_TERM_EN
        chk($sformatf("early_term lat%0d m%0d", plat, m), t, g.et, 0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; max_itr = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Called just after a clock edge with both DUTs idle; that cycle is t=0.
    task automatic run(input int m, input int spur, input int extra);
        int tend = 2 * m * (NADDR + 4) + 1 + extra;
        start = 1'b1; max_itr = 5'(m);
        for (int t = 0; t <= tend; t++) begin
            @(negedge clk);
            check_cycle(t, m, 4, sample(0));
            check_cycle(t, m, 1, sample(1));
            @(posedge clk); #1;
            start = (t + 1 == spur);
            if (start) max_itr = 5'($urandom_range(0, 31));
        end
        start = 1'b0;
    endtask

    initial begin
        vec_t vecs[$];
        obs_t g;
        int   stray;
        int   m, spur;

        vecs.push_back('{4, 2,  0, 0,  0, 0, -1, -1, -1, 0, 0});
        vecs.push_back('{4, 2,  1, 1,  0, 0,  0,  1,  0, 1, 0});
        vecs.push_back('{4, 2, 20, 1, 19, 1,  0,  1,  0, 1, 0});
        vecs.push_back('{4, 2, 21, 0,  0, 1,  0,  1,  0, 1, 0});
        vecs.push_back('{4, 2, 24, 0,  0, 1,  0,  1,  0, 1, 0});
        vecs.push_back('{4, 2, 25, 1,  0, 0,  1,  1,  0, 1, 0});
        vecs.push_back('{4, 2, 48, 0,  0, 1,  1,  1,  0, 1, 0});
        vecs.push_back('{4, 2, 49, 1,  0, 0,  0,  0,  1, 1, 0});
        vecs.push_back('{4, 2, 92, 1, 19, 1,  1,  0,  1, 1, 0});
        vecs.push_back('{4, 2, 96, 0,  0, 1,  1,  0,  1, 1, 0});
        vecs.push_back('{4, 2, 97, 0,  0, 0, -1, -1,  1, 0, 1});
        vecs.push_back('{4, 2, 98, 0,  0, 0, -1, -1, -1, 0, 0});
        vecs.push_back('{4, 0,  1, 0,  0, 0, -1, -1, -1, 0, 1});
        vecs.push_back('{4, 0,  2, 0,  0, 0, -1, -1, -1, 0, 0});
        vecs.push_back('{1, 1,  2, 1,  1, 1,  0,  1,  0, 1, 0});
        vecs.push_back('{1, 1, 21, 0,  0, 1,  0,  1,  0, 1, 0});
        vecs.push_back('{1, 1, 22, 1,  0, 0,  1,  1,  0, 1, 0});
        vecs.push_back('{1, 1, 42, 0,  0, 1,  1,  1,  0, 1, 0});
        vecs.push_back('{1, 1, 43, 0,  0, 0, -1, -1,  0, 0, 1});

        rst = 1'b1; start = 1'b0; max_itr = '0;
`ifdef LMEM_SCHED_EARLY_TERM_EN
        syn_ok = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        g = sample(0);
        chk("reset rd_en", 0, g.rd, 0);
        chk("reset rd_address", 0, g.addr, 0);
        chk("reset wr_en", 0, g.wr, 0);
        chk("reset layer", 0, g.layer, 0);
        chk("reset firstiter", 0, g.first, 0);
        chk("reset itr", 0, g.itr, 0);
        chk("reset busy", 0, g.busy, 0);
        chk("reset done", 0, g.done, 0);

        foreach (vecs[i]) begin
            do_reset();
            start = 1'b1; max_itr = 5'(vecs[i].m);
            for (int c = 0; c < vecs[i].t; c++) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            @(negedge clk);
            g = sample((vecs[i].lat == 1) ? 1 : 0);
            chk("vec rd_en", i, g.rd, vecs[i].rd);
            chk("vec rd_address", i, g.addr, vecs[i].addr);
            chk("vec wr_en", i, g.wr, vecs[i].wr);
            chk("vec busy", i, g.busy, vecs[i].busy);
            chk("vec done", i, g.done, vecs[i].done);
            if (vecs[i].layer >= 0) chk("vec layer", i, g.layer, vecs[i].layer);
            if (vecs[i].first >= 0) chk("vec firstiter", i, g.first, vecs[i].first);
            if (vecs[i].itr >= 0) chk("vec itr", i, g.itr, vecs[i].itr);
        end

        // Full run with a stray start in cycle 10.
        do_reset();
        run(2, 10, 3);

        // Reset in cycle 30 while writes are still in flight.
        do_reset();
        start = 1'b1; max_itr = 5'd2;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        g = sample(0);
        chk("wr_en before mid-run reset", 30, g.wr, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        g = sample(0);
        chk("post-reset rd_en", 31, g.rd, 0);
        chk("post-reset rd_address", 31, g.addr, 0);
        chk("post-reset wr_en", 31, g.wr, 0);
        chk("post-reset layer", 31, g.layer, 0);
        chk("post-reset firstiter", 31, g.first, 0);
        chk("post-reset itr", 31, g.itr, 0);
        chk("post-reset busy", 31, g.busy, 0);
        chk("post-reset done", 31, g.done, 0);
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            stray += int'(wr0) + int'(rd0) + int'(wr1) + int'(rd1) + int'(busy0) + int'(busy1);
        end
        chk("activity after reset", 71, stray, 0);
        @(posedge clk); #1;
        run(1, -1, 2);

        // Randomised runs, some with a stray start while busy.
        for (int r = 0; r < 6; r++) begin
            m = $urandom_range(0, 3);
            spur = (m > 0 && ($urandom_range(0, 1) == 1)) ? $urandom_range(1, 2 * m * (NADDR + 1)) : -1;
            run(m, spur, $urandom_range(1, 4));
        end

`ifdef LMEM_SCHED_EARLY_TERM_EN
        do_reset();
        start = 1'b1; max_itr = 5'd5;
        for (int t = 0; t <= 51; t++) begin
            @(negedge clk);
            g = sample(0);
            if (t >= 48 && t <= 50) begin
                chk("early-exit done", t, g.done, (t == 49) ? 1 : 0);
                chk("early-exit early_term", t, g.et, (t == 49) ? 1 : 0);
            end
            if (t == 49) chk("early-exit itr", t, g.itr, 0);
            if (t == 50) chk("early-exit busy", t, g.busy, 0);
            @(posedge clk); #1;
            start = 1'b0;
            syn_ok = (t + 1 == 48);
        end
        syn_ok = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
